// File: rtl/alu_sequencer_if.sv
// Request handshake between a requester and alu_sequencer.
// master drives valid/op/a/b and reads ready; slave is the reverse.
interface alu_sequencer_if;
  logic        req_valid;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-state sequencer holding ALU operands for an opcode-dependent number
// of cycles, then capturing the 64-bit result into Z.
// Ports: clk, clr (async active-high), req (slave handshake: valid/op/a/b/
// ready), alu_op/alu_a/alu_b to the ALU, alu_result from it, z_hi/z_lo
// captured result, done pulse, sticky err, busy.
// Optional: define DIV_ZERO_CHECK_EN to reject DIV with a zero divisor.
module alu_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic           clk,
  input  logic           clr,
  alu_sequencer_if.slave req,
  output logic [4:0]     alu_op,
  output logic [31:0]    alu_a,
  output logic [31:0]    alu_b,
  input  logic [63:0]    alu_result,
  output logic [31:0]    z_hi,
  output logic [31:0]    z_lo,
  output logic           done,
  output logic           err,
  output logic           busy
);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_len;
  logic [4:0]  r_alu_op;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_z_hi;
  logic [31:0] r_z_lo;
  logic        r_done;
  logic        r_err;
  logic        w_accept;
  logic        w_op_ok;
  logic        w_legal;
  logic        w_start;
  logic        w_reject;
  logic        w_last;

  always_comb begin
    w_op_ok = 1'b0;
    case (req.req_op)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01010, 5'b01011,
      5'b01111, 5'b10000, 5'b10001,
      5'b10010: w_op_ok = 1'b1;
      default:  w_op_ok = 1'b0;
    endcase
  end

`ifdef DIV_ZERO_CHECK_EN
  assign w_legal = w_op_ok &
    ~((req.req_op == OP_DIV) &
      (req.req_b == 32'd0));
`else
  assign w_legal = w_op_ok;
`endif

  // Counter is loaded with L-1 so that
  // r_cnt==0 marks the final EXEC cycle.
  always_comb begin
    w_len = 4'd0;
    if (req.req_op == OP_MUL)
      w_len = 4'(MUL_CYCLES - 1);
    else if (req.req_op == OP_DIV)
      w_len = 4'(DIV_CYCLES - 1);
  end

  assign w_accept = req.req_valid &
                    (r_state == S_IDLE);
  assign w_start  = w_accept & w_legal;
  assign w_reject = w_accept & ~w_legal;
  assign w_last   = (r_state == S_EXEC) &
                    (r_cnt == 4'd0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_EXEC;
      S_EXEC: if (w_last)  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = (r_state == S_IDLE);
    busy          = (r_state == S_EXEC);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt    <= 4'd0;
      r_alu_op <= 5'd0;
      r_alu_a  <= 32'd0;
      r_alu_b  <= 32'd0;
      r_z_hi   <= 32'd0;
      r_z_lo   <= 32'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_last | w_reject;
      if (w_reject)
        r_err <= 1'b1;
      if (w_start) begin
        r_alu_op <= req.req_op;
        r_alu_a  <= req.req_a;
        r_alu_b  <= req.req_b;
        r_cnt    <= w_len;
      end else if (w_last) begin
        r_z_hi   <= alu_result[63:32];
        r_z_lo   <= alu_result[31:0];
        r_alu_op <= 5'd0;
        r_alu_a  <= 32'd0;
        r_alu_b  <= 32'd0;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign alu_op = r_alu_op;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;
  assign z_hi   = r_z_hi;
  assign z_lo   = r_z_lo;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU model
// and a reference model of acceptance, latency and Z/err behaviour.
module tb_alu_sequencer;

  logic        clk;
  logic        clr;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_result;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        done;
  logic        err;
  logic        busy;

  int          n_checks;
  int          n_fail;
  logic [63:0] exp_z;
  logic        exp_err;

  logic [4:0] legal_ops [13] = '{
    5'b00011, 5'b00100, 5'b00101, 5'b00110,
    5'b00111, 5'b01000, 5'b01001, 5'b01010,
    5'b01011, 5'b01111, 5'b10000, 5'b10001,
    5'b10010};

  alu_sequencer_if bus ();

  alu_sequencer #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .z_hi       (z_hi),
    .z_lo       (z_lo),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] p;
    case (op)
      5'b00011: p = {32'd0, a + b};
      5'b00100: p = {32'd0, a - b};
      5'b00101: p = {32'd0, a & b};
      5'b00110: p = {32'd0, a | b};
      5'b00111: p = {32'd0, a ^ b};
      5'b01000: p = {32'd0, a << b[4:0]};
      5'b01001: p = {32'd0, a >> b[4:0]};
      5'b01111: p = {32'd0, a} * {32'd0, b};
      5'b10000:
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else            p = {a % b, a / b};
      default:  p = {32'd0, a ^ ~b};
    endcase
    return p;
  endfunction

  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  function automatic bit is_legal(
    input logic [4:0] op,
    input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    foreach (legal_ops[i])
      if (legal_ops[i] == op) ok = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
    if (op == 5'b10000 && b == 32'd0) ok = 1'b0;
`else
    if (b == 32'hDEAD_0000) ok = ok;
`endif
    return ok;
  endfunction

  function automatic int lat_of(input logic [4:0] op);
    if (op == 5'b01111) return 4;
    if (op == 5'b10000) return 8;
    return 1;
  endfunction

  // Presents one request (caller guarantees the DUT is idle at the
  // next edge) and observes edges-to-done and operand stability.
  task automatic do_op(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output bit          stable);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    stable = 1'b1;
    lat    = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (alu_op !== op || alu_a !== a ||
          alu_b !== b || busy !== 1'b1 ||
          bus.req_ready !== 1'b0)
        stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 5'd0;
    bus.req_a = 32'd0;
    bus.req_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({alu_op, alu_a, alu_b} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_alu: got %h want 0",
               {alu_op, alu_a, alu_b});
    end
    n_checks++;
    if ({z_hi, z_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_z: got %h want 0", {z_hi, z_lo});
    end
    n_checks++;
    if ({done, err, busy, bus.req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0001",
               {done, err, busy, bus.req_ready});
    end
    exp_z = 64'd0;
    exp_err = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    bit st;
    do_op(5'b00011, 32'd5, 32'd7, lat, st);
    exp_z = 64'd12;
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL add_latency: got %0d want 1", lat);
    end
    n_checks++;
    if ({z_hi, z_lo} !== exp_z || err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got z=%h err=%b want z=%h err=0",
               {z_hi, z_lo}, err, exp_z);
    end
    n_checks++;
    if (alu_op !== 5'd0 || bus.req_ready !== 1'b1 ||
        busy !== 1'b0 || !st) begin
      n_fail++;
      $display("FAIL add_done_state: got op=%h rdy=%b busy=%b st=%b want 0 1 0 1",
               alu_op, bus.req_ready, busy, st);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_mul;
    int lat;
    bit st;
    do_op(5'b01111, 32'h10000, 32'h10000, lat, st);
    exp_z = 64'h1_0000_0000;
    n_checks++;
    if (lat !== 4 || !st) begin
      n_fail++;
      $display("FAIL mul_timing: got lat=%0d st=%b want 4 1", lat, st);
    end
    n_checks++;
    if (z_hi !== 32'd1 || z_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL mul_result: got %h_%h want 1_0", z_hi, z_lo);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_div_back_to_back;
    int lat;
    bit st;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b10000;
    bus.req_a = 32'd17;
    bus.req_b = 32'd5;
    @(posedge clk);
    #1;
    bus.req_op = 5'b00011;
    bus.req_a = 32'd100;
    bus.req_b = 32'd23;
    st = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (alu_op !== 5'b10000 || alu_a !== 32'd17 ||
          alu_b !== 32'd5)
        st = 1'b0;
    end
    exp_z = {32'd2, 32'd3};
    n_checks++;
    if (lat !== 8 || !st) begin
      n_fail++;
      $display("FAIL div_timing: got lat=%0d st=%b want 8 1", lat, st);
    end
    n_checks++;
    if ({z_hi, z_lo} !== exp_z || err !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL div_result: got z=%h err=%b rdy=%b want %h 0 1",
               {z_hi, z_lo}, err, bus.req_ready, exp_z);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (alu_op !== 5'b00011 || alu_a !== 32'd100 ||
        busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got op=%h a=%0d busy=%b done=%b want 03 100 1 0",
               alu_op, alu_a, busy, done);
    end
    @(posedge clk);
    #1;
    exp_z = 64'd123;
    n_checks++;
    if (done !== 1'b1 || {z_hi, z_lo} !== exp_z || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got done=%b z=%h err=%b want 1 %h 0",
               done, {z_hi, z_lo}, err, exp_z);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    bit st;
    do_op(5'b10000, 32'd9, 32'd0, lat, st);
`ifdef DIV_ZERO_CHECK_EN
    exp_err = 1'b1;
    n_checks++;
    if (lat !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL divz_reject: got lat=%0d busy=%b want 0 0", lat, busy);
    end
`else
    exp_z = {32'd9, 32'hFFFF_FFFF};
    n_checks++;
    if (lat !== 8 || !st) begin
      n_fail++;
      $display("FAIL divz_exec: got lat=%0d st=%b want 8 1", lat, st);
    end
`endif
    n_checks++;
    if ({z_hi, z_lo} !== exp_z || err !== exp_err) begin
      n_fail++;
      $display("FAIL divz_result: got z=%h err=%b want %h %b",
               {z_hi, z_lo}, err, exp_z, exp_err);
    end
  endtask

  task automatic test_illegal;
    int lat;
    bit st;
    do_op(5'b11111, 32'd1, 32'd2, lat, st);
    exp_err = 1'b1;
    n_checks++;
    if (lat !== 0 || busy !== 1'b0 || alu_op !== 5'd0) begin
      n_fail++;
      $display("FAIL ill_reject: got lat=%0d busy=%b op=%h want 0 0 0",
               lat, busy, alu_op);
    end
    n_checks++;
    if ({z_hi, z_lo} !== exp_z || err !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_state: got z=%h err=%b want %h 1",
               {z_hi, z_lo}, err, exp_z);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_pulse: got done=%b err=%b want 0 1", done, err);
    end
    do_op(5'b00011, 32'd40, 32'd2, lat, st);
    exp_z = 64'd42;
    n_checks++;
    if (lat !== 1 || {z_hi, z_lo} !== exp_z || err !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_then_add: got lat=%0d z=%h err=%b want 1 %h 1",
               lat, {z_hi, z_lo}, err, exp_z);
    end
  endtask

  task automatic test_random;
    int lat;
    bit st;
    logic [4:0] op;
    logic [31:0] a;
    logic [31:0] b;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9) < 8)
        op = legal_ops[$urandom_range(12)];
      else
        op = 5'($urandom);
      a = $urandom;
      b = $urandom;
      if (op == 5'b10000 && $urandom_range(7) == 0) b = 32'd0;
      if (op == 5'b10000 && $urandom_range(1) == 0) b = b >> 20;
      ok = is_legal(op, b);
      do_op(op, a, b, lat, st);
      if (ok) exp_z = ref_alu(op, a, b);
      else    exp_err = 1'b1;
      n_checks++;
      if (lat !== (ok ? lat_of(op) : 0) || (ok && !st)) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d]: op=%b got lat=%0d st=%b want lat=%0d",
                 i, op, lat, st, ok ? lat_of(op) : 0);
      end
      n_checks++;
      if ({z_hi, z_lo} !== exp_z || err !== exp_err) begin
        n_fail++;
        $display("FAIL rnd_result[%0d]: op=%b got z=%h err=%b want %h %b",
                 i, op, {z_hi, z_lo}, err, exp_z, exp_err);
      end
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_clr_abort;
    int lat;
    bit st;
    bit saw_done;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b01111;
    bus.req_a = 32'd3;
    bus.req_b = 32'd4;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    n_checks++;
    if ({alu_op, alu_a, alu_b} !== 69'd0 || {z_hi, z_lo} !== 64'd0 ||
        {done, err, busy, bus.req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_abort: got op=%h z=%h flags=%b want 0 0 0001",
               alu_op, {z_hi, z_lo}, {done, err, busy, bus.req_ready});
    end
    exp_z = 64'd0;
    exp_err = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done || {z_hi, z_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL clr_no_done: got act=%b z=%h want 0 0",
               saw_done, {z_hi, z_lo});
    end
    do_op(5'b00100, 32'd50, 32'd8, lat, st);
    exp_z = 64'd42;
    n_checks++;
    if (lat !== 1 || {z_hi, z_lo} !== exp_z || err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_then_sub: got lat=%0d z=%h err=%b want 1 %h 0",
               lat, {z_hi, z_lo}, err, exp_z);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_add();
    test_mul();
    test_div_back_to_back();
    @(posedge clk);
    #1;
    test_div_zero();
    test_illegal();
    test_random();
    test_clr_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
